// File: rtl/palette_layer_mapper.sv
// palette_layer_mapper
//   Composites N_LAYERS sprite palette indices per pixel, resolves
//   transparency and priority, and converts the winning index to RGB through
//   a double-buffered, software-writable palette. Software writes go to a
//   shadow copy. A frame_start pulse copies the whole shadow into the active
//   copy in one cycle, so a frame never shows a half-updated palette.
//
//   Pipeline (2 cycles, one pixel per cycle, no stalls):
//     stage 1 : priority select -> sel_idx, sel_valid
//     stage 2 : active[sel_idx] -> VGA_R/G/B (0 while blanked), pix_valid_out
//
// Ports
//   Clk            pixel clock
//   Reset          asynchronous, active-high; restores default palettes
//   layer_idx      N_LAYERS packed indices, layer k at [k*IDX_W +: IDX_W]
//   pix_valid_in   active-video qualifier for layer_idx
//   frame_start    1-cycle pulse, commits shadow -> active
//   wr_en          shadow palette write strobe
//   wr_addr        shadow entry to write
//   wr_data        {R,G,B} for the shadow entry
//   VGA_R/G/B      registered pixel color
//   pix_valid_out  pix_valid_in delayed by 2 cycles
module palette_layer_mapper #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned N_LAYERS = 2,
    parameter int unsigned COLOR_W  = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                      pix_valid_in,
    input  logic                      frame_start,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic [3*COLOR_W-1:0]      wr_data,
    output logic [COLOR_W-1:0]        VGA_R,
    output logic [COLOR_W-1:0]        VGA_G,
    output logic [COLOR_W-1:0]        VGA_B,
    output logic                      pix_valid_out
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    // Default palette, specified at 8 bits per channel. Narrower channels keep
    // the top COLOR_W bits; wider channels are left-justified with zero fill.
    function automatic logic [3*COLOR_W-1:0] default_color(input int unsigned i);
        logic [23:0]          rgb;
        logic [3*COLOR_W-1:0] res;
        case (i)
            0:       rgb = 24'h40E0D0;
            1:       rgb = 24'h161616;
            2:       rgb = 24'hF8F8F8;
            3:       rgb = 24'hDDC06B;
            4:       rgb = 24'h00CFDF;
            5:       rgb = 24'h00699F;
            6:       rgb = 24'h0160C5;
            7:       rgb = 24'hA61814;
            8:       rgb = 24'h2BD9CC;
            9:       rgb = 24'h949494;
            10:      rgb = 24'h84F8B8;
            default: rgb = 24'h40E0D0;
        endcase
        res = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            for (int unsigned b = 0; b < COLOR_W; b++) begin
                if (b + 8 >= COLOR_W)
                    res[ch*COLOR_W + b] = rgb[ch*8 + b + 8 - COLOR_W];
            end
        end
        return res;
    endfunction

    logic [3*COLOR_W-1:0] shadow [DEPTH];
    logic [3*COLOR_W-1:0] active [DEPTH];

    logic [IDX_W-1:0]     sel_comb;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;
    logic [3*COLOR_W-1:0] lookup;

    // Highest-numbered layer with a nonzero (non-transparent) index wins;
    // all-transparent falls through to index 0, the background entry.
    always_comb begin
        sel_comb = '0;
        for (int unsigned k = 0; k < N_LAYERS; k++) begin
            if (layer_idx[k*IDX_W +: IDX_W] != '0)
                sel_comb = layer_idx[k*IDX_W +: IDX_W];
        end
    end

    // Shadow palette: plain write port, last write wins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                shadow[i] <= default_color(i);
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // Active palette: full copy on commit. A write landing in the commit
    // cycle is forwarded so it is not lost until the next frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                active[i] <= default_color(i);
        end else if (frame_start) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                active[i] <= (wr_en && wr_addr == IDX_W'(i)) ? wr_data : shadow[i];
        end
    end

    // Stage 1: registered selection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sel_idx   <= '0;
            sel_valid <= 1'b0;
        end else begin
            sel_idx   <= sel_comb;
            sel_valid <= pix_valid_in;
        end
    end

    // Stage 2 reads the active palette as it stands before the current edge,
    // so a commit on this edge affects the following lookup onward.
    assign lookup = active[sel_idx];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_R         <= '0;
            VGA_G         <= '0;
            VGA_B         <= '0;
            pix_valid_out <= 1'b0;
        end else begin
            pix_valid_out <= sel_valid;
            if (sel_valid) begin
                VGA_R <= lookup[3*COLOR_W-1 -: COLOR_W];
                VGA_G <= lookup[2*COLOR_W-1 -: COLOR_W];
                VGA_B <= lookup[COLOR_W-1   -: COLOR_W];
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_layer_mapper.sv
// Directed bench for palette_layer_mapper with default parameters
// (IDX_W=4, N_LAYERS=2, COLOR_W=8). Inputs change 1 time unit after a rising
// edge; outputs are checked 1 time unit after a rising edge.
module tb_palette_layer_mapper;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  layer_idx;
    logic        pix_valid_in;
    logic        frame_start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid_out;

    int checks   = 0;
    int failures = 0;

    palette_layer_mapper #(.IDX_W(4), .N_LAYERS(2), .COLOR_W(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .layer_idx    (layer_idx),
        .pix_valid_in (pix_valid_in),
        .frame_start  (frame_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .pix_valid_out(pix_valid_out)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        logic [23:0] obs;
        obs = {VGA_R, VGA_G, VGA_B};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s rgb observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_valid(input string tag, input logic exp);
        checks++;
        assert (pix_valid_out === exp) else begin
            failures++;
            $error("FAIL %s pix_valid_out observed %b expected %b", tag, pix_valid_out, exp);
        end
    endtask

    // Present one pixel, hold it through both stages, then check.
    task automatic lookup(input string tag, input logic [3:0] l1, input logic [3:0] l0,
                          input logic [23:0] exp);
        layer_idx    = {l1, l0};
        pix_valid_in = 1'b1;
        step();
        step();
        check_rgb(tag, exp);
        check_valid(tag, 1'b1);
    endtask

    task automatic write(input logic [3:0] addr, input logic [23:0] data, input logic commit);
        wr_en       = 1'b1;
        wr_addr     = addr;
        wr_data     = data;
        frame_start = commit;
        step();
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        layer_idx    = '0;
        pix_valid_in = 1'b0;
        frame_start  = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        step();
        step();
        check_rgb("reset", 24'h000000);
        check_valid("reset", 1'b0);
        Reset = 1'b0;
        step();
        check_rgb("idle_after_reset", 24'h000000);
        check_valid("idle_after_reset", 1'b0);

        // Defaults and priority
        lookup("l0_idx7", 4'd0, 4'd7, 24'hA61814);
        lookup("prio_5_over_3", 4'd5, 4'd3, 24'h00699F);
        lookup("l1_transparent", 4'd0, 4'd3, 24'hDDC06B);
        lookup("all_transparent", 4'd0, 4'd0, 24'h40E0D0);
        lookup("l1_idx10", 4'd10, 4'd0, 24'h84F8B8);
        lookup("l1_idx15_top", 4'd15, 4'd9, 24'h40E0D0);
        lookup("l0_idx9", 4'd0, 4'd9, 24'h949494);

        // Shadow write must not leak into the active palette before commit
        write(4'd7, 24'h00FF00, 1'b0);
        lookup("shadow_hidden", 4'd0, 4'd7, 24'hA61814);
        commit();
        lookup("after_commit", 4'd0, 4'd7, 24'h00FF00);

        // Back-to-back writes to one address: last wins
        write(4'd4, 24'h111111, 1'b0);
        write(4'd4, 24'h222222, 1'b0);
        commit();
        lookup("last_write_wins", 4'd4, 4'd0, 24'h222222);

        // Write in the commit cycle is forwarded
        write(4'd2, 24'hFFFF00, 1'b1);
        lookup("fwd_write_commit", 4'd2, 4'd0, 24'hFFFF00);

        // Commit mid-stream: pixel in stage 2 on the commit edge sees old color
        write(4'd5, 24'hABCDEF, 1'b0);
        layer_idx    = {4'd5, 4'd0};
        pix_valid_in = 1'b1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_rgb("commit_edge_old", 24'h00699F);
        step();
        check_rgb("commit_edge_new", 24'hABCDEF);

        // Blanking: valid pattern 1,0,1 with a nonzero index throughout
        layer_idx    = {4'd0, 4'd3};
        pix_valid_in = 1'b0;
        step();
        step();
        check_valid("blank_pre", 1'b0);
        check_rgb("blank_pre", 24'h000000);
        pix_valid_in = 1'b1;
        step();
        pix_valid_in = 1'b0;
        step();
        check_rgb("toggle_1", 24'hDDC06B);
        check_valid("toggle_1", 1'b1);
        pix_valid_in = 1'b1;
        step();
        pix_valid_in = 1'b0;
        check_rgb("toggle_0", 24'h000000);
        check_valid("toggle_0", 1'b0);
        step();
        check_rgb("toggle_1b", 24'hDDC06B);
        check_valid("toggle_1b", 1'b1);
        step();
        check_valid("toggle_end", 1'b0);

        // Reset mid-stream with a pending shadow write
        write(4'd3, 24'h123456, 1'b0);
        lookup("pre_reset", 4'd0, 4'd7, 24'h00FF00);
        #2;
        Reset = 1'b1;
        #1;
        check_rgb("async_reset", 24'h000000);
        check_valid("async_reset", 1'b0);
        step();
        Reset = 1'b0;
        lookup("post_reset_idx7", 4'd0, 4'd7, 24'hA61814);
        commit();
        lookup("pending_write_lost", 4'd0, 4'd3, 24'hDDC06B);
        lookup("post_reset_idx2", 4'd2, 4'd0, 24'hF8F8F8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
